// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line among NUM_REQ requesters (8N1).
// Define UART_ARB_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_arbiter #(
    parameter int CLK_VALUE  = 100_000,
    parameter int BAUD       = 9600,
    parameter int WAIT_COUNT = CLK_VALUE / BAUD,
    parameter int NUM_REQ    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 done,
    output logic                 busy,
    output logic                 tx
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WAIT_COUNT);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_ARB_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 tx_q, tx_d;
`ifdef UART_ARB_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic [NUM_REQ-1:0][7:0] bytes;
    logic                    found;
    logic [PW-1:0]           sel;
    logic [PW-1:0]           idx;
    logic                    bit_end;

    assign bytes = data_in;

    // Scan from high offset to low so the last hit is the first set bit at or after ptr.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
`ifdef UART_ARB_PARITY_EN
        par_d     = par_q;
`endif
        bit_end   = (cnt_q == CW'(WAIT_COUNT - 1));

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d   = START;
                    owner_d   = sel;
                    shreg_d   = bytes[sel];
                    bit_idx_d = '0;
`ifdef UART_ARB_PARITY_EN
                    par_d     = ^bytes[sel];
`endif
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_ARB_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        // Outputs are derived from next-state values so they register on the same edge.
        grant_d = '0;
        if (state_d != IDLE) grant_d[owner_d] = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CW'(WAIT_COUNT - 1));
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_ARB_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
`ifdef UART_ARB_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
`ifdef UART_ARB_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame table with round-robin order, plus mid-frame
// input change and mid-frame reset sequences. Honours UART_ARB_PARITY_EN for frame length.
module tb_uart_tx_arbiter;
    localparam int W = 10;
    localparam int N = 4;
`ifdef UART_ARB_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic           done, busy, tx;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.CLK_VALUE(100_000), .BAUD(9600), .WAIT_COUNT(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .grant(grant), .done(done), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_g;
        logic [7:0]  exp_b;
        bit          chk_gap;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int slot, input logic [7:0] b);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_ARB_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Waits (bounded) for busy; returns at the negedge of the first frame cycle.
    task automatic wait_start(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, " start"}, 32'(ok), 32'd1);
    endtask

    // Called at negedge of frame cycle 1; ends at negedge of the idle gap cycle.
    task automatic run_frame(input string nm, input logic [3:0] eg, input logic [7:0] b,
                             input int change_at, input int reset_at);
        int bad_g = 0, bad_b = 0, bad_tx = 0, bad_d = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge clk);
            if (c == reset_at) begin
                rst = 1'b1;
                #1;
                chk({nm, " rst tx"},    32'(tx),    32'd1);
                chk({nm, " rst grant"}, 32'(grant), 32'd0);
                chk({nm, " rst busy"},  32'(busy),  32'd0);
                chk({nm, " rst done"},  32'(done),  32'd0);
                return;
            end
            if (grant !== eg) bad_g++;
            if (busy !== 1'b1) bad_b++;
            if (tx !== exp_bit((c - 1) / W, b)) bad_tx++;
            if (done !== (c == FRAME)) bad_d++;
            if (c == change_at) begin
                req = '0;
                data_in = ~data_in;
            end
        end
        chk({nm, " grant cycles"}, 32'(bad_g), 32'd0);
        chk({nm, " busy cycles"},  32'(bad_b), 32'd0);
        chk({nm, " tx bits"},      32'(bad_tx), 32'd0);
        chk({nm, " done pulse"},   32'(bad_d), 32'd0);
        @(negedge clk);
        chk({nm, " gap busy"},  32'(busy),  32'd0);
        chk({nm, " gap grant"}, 32'(grant), 32'd0);
        chk({nm, " gap tx"},    32'(tx),    32'd1);
    endtask

    initial begin
        vec_t v[12];
        bit   ok;
        time  t_prev;
        v[0]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5, 1'b0};
        v[1]  = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 1'b1};
        v[2]  = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 1'b1};
        v[3]  = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 1'b1};
        v[4]  = '{4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 1'b1};
        v[5]  = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 1'b1};
        v[6]  = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 1'b1};
        v[7]  = '{4'b0101, 32'h4433_2211, 4'b0001, 8'h11, 1'b1};
        v[8]  = '{4'b0101, 32'h4433_2211, 4'b0100, 8'h33, 1'b1};
        v[9]  = '{4'b1010, 32'h00FF_8001, 4'b1000, 8'h00, 1'b1};
        v[10] = '{4'b1010, 32'h00FF_8001, 4'b0010, 8'h80, 1'b1};
        v[11] = '{4'b0100, 32'h0007_0000, 4'b0100, 8'h07, 1'b1};
        t_prev = 0;

        repeat (2) @(negedge clk);
        chk("reset tx",    32'(tx),    32'd1);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset done",  32'(done),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            req = v[i].req;
            data_in = v[i].data;
            wait_start($sformatf("vec%0d", i), ok);
            if (ok) begin
                if (v[i].chk_gap)
                    chk($sformatf("vec%0d spacing", i), 32'($time - t_prev), 32'((FRAME + 1) * 10));
                t_prev = $time;
                run_frame($sformatf("vec%0d", i), v[i].exp_g, v[i].exp_b, 0, 0);
            end
        end

        // Inputs change mid-DATA (bit 3); frame must still follow the latched byte.
        req = 4'b0001;
        data_in = 32'h0000_005A;
        wait_start("midchg", ok);
        if (ok) run_frame("midchg", 4'b0001, 8'h5A, 45, 0);

        // Reset at cycle 45; priority then restarts at requester 0.
        req = 4'b0010;
        data_in = 32'h0000_C300;
        wait_start("rstmid", ok);
        if (ok) run_frame("rstmid", 4'b0010, 8'hC3, 0, 45);
        @(negedge clk);
        chk("in reset tx",   32'(tx),   32'd1);
        chk("in reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        data_in = 32'h4433_2211;
        wait_start("postrst", ok);
        if (ok) run_frame("postrst", 4'b0001, 8'h11, 0, 0);
        req = '0;
        repeat (3) @(negedge clk);
        chk("final idle busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line among `NUM_REQ` requesters. The block contains its own bit-period counter, derived from the same clock/baud parameters as the baud rate generator, and a frame state machine. A round-robin arbiter picks one requester, latches its byte, and serialises it as 8N1 (start bit, 8 data bits LSB first, stop bit). It sits between the per-channel producers and the physical `tx` pin.

## Interface
- `CLK_VALUE`, 100_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `WAIT_COUNT`, `CLK_VALUE/BAUD` (10 at defaults): clock cycles per bit period. Legal values are ≥ 2.
- `NUM_REQ`, 4: number of requesters. Legal range is 2..8.
- `clk`  in  1: the only clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  `NUM_REQ`: level request, one bit per requester.
- `data_in`  in  `8*NUM_REQ`: byte for requester i is `data_in[8*i+7:8*i]`.
- `grant`  out  `NUM_REQ`: one-hot. Held high for the owner for the whole frame.
- `done`  out  1: one-cycle pulse in the last cycle of the stop bit.
- `busy`  out  1: high whenever the state is not IDLE.
- `tx`  out  1: serial line. Idles high.

## Operation
- States: IDLE → START → DATA → STOP → IDLE. With the parity option compiled in, the sequence is DATA → PARITY → STOP.
- IDLE:
  - `cnt` is held at 0.
  - If any `req` bit is set, the arbiter selects the first set bit, searching upward from `ptr` and wrapping modulo `NUM_REQ`.
  - On the selecting edge the block latches that requester's byte into `shreg`, sets `grant` one-hot, and enters START.
- Bit timing:
  - `cnt` counts 0..`WAIT_COUNT`-1 in START, DATA, PARITY and STOP.
  - When `cnt` == `WAIT_COUNT`-1, the current bit ends and `cnt` returns to 0.
- START: `tx`=0 for one bit period.
- DATA:
  - `tx`=`shreg[0]`.
  - At the end of each bit, `shreg` shifts right and `bit_idx` increments.
  - After `bit_idx`==7 completes, the next state is STOP (or PARITY).
- STOP:
  - `tx`=1 for one bit period.
  - `done`=1 in its final cycle.
  - The next state is IDLE, `grant` clears, and `ptr` is set to (owner+1) mod `NUM_REQ`.
- Requests are ignored while `busy`. Dropping `req` mid-frame does not abort the frame, and `data_in` changes after latching have no effect.
- Requesters must deassert `req`, or present a new byte, after seeing `done`. A `req` still high in the first IDLE cycle is re-granted only if the round-robin scan reaches it.

## Timing
- Reset values: `tx`=1, `grant`=0, `done`=0, `busy`=0, state=IDLE, `ptr`=0, `cnt`=0, `bit_idx`=0, `shreg`=0.
- Latency: `req` is sampled high at edge N. `grant`, `busy` and `tx`=0 are all visible after edge N.
- Frame length is 10×`WAIT_COUNT` cycles (100 at defaults), or 11×`WAIT_COUNT` with parity.
- `done` is high in the cycle before `busy` falls.
- Minimum gap between frames is 1 IDLE cycle, so back-to-back frames are spaced 10×`WAIT_COUNT`+1 cycles start-to-start.
- Simultaneous requests: exactly one grant, per round-robin order from `ptr`.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously) and the partial frame is lost. `tx` returns high with no glitch low.
- `ptr` wraps from `NUM_REQ`-1 to 0.

## Configuration
- `UART_ARB_PARITY_EN` defined:
  - A PARITY state follows DATA.
  - `tx` = even parity, i.e. the XOR of the latched byte, for one bit period.
  - Frame is 11 bit periods.
- Not defined: no PARITY state, the frame is 8N1, and no parity logic is synthesised.

## Test plan
- Reset, then `req`=4'b0001 with `data_in[7:0]`=8'hA5:
  - `tx` shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, with each bit lasting 10 cycles.
  - `grant`=4'b0001 for 100 cycles.
  - `done` pulses at cycle 100.
- `req`=4'b1111 held continuously:
  - Grants rotate 0001→0010→0100→1000→0001.
  - Each frame starts 101 cycles after the previous one.
- After requester 2 finishes (`ptr`=3), assert `req`=4'b0101: requester 0 is granted next, because the scan wraps from 3.
- Mid-DATA on bit 3, deassert `req` and change `data_in`: the remaining bits still follow the latched byte, and `done` pulses on schedule.
- Assert `rst` at cycle 45 of a frame: `tx`=1, `grant`=0 and `busy`=0 at once. A new request after release starts a full, clean frame, and priority restarts at requester 0.
- With `UART_ARB_PARITY_EN` defined, send 8'h07: the parity bit is 1, the frame is 110 cycles, and `done` pulses at cycle 110.
